wishbone_master_burst: RTL and testbench
========================================

Name: wishbone_master_burst

Overview:
Parametrised successor to the single-beat wishbone master used between the JTAG TAP and the debug-module slave.
- Accepts a command (read/write, start address, beat count) over a valid/ready handshake.
- Executes it as a classic Wishbone burst: cyc held for the whole burst, stb per beat, address auto-incremented by a stride.
- Write data is pulled per beat over a handshake; read data is returned per beat.
- Adds bus-error and no-ack timeout abort with completion status.

Parameters:
DATA_WIDTH, 32, width of Wishbone data buses and user data ports
ADDR_WIDTH, 32, width of Wishbone address and command address
LEN_W, 4, width of cmd_len_i; max burst = 2**LEN_W beats
ADDR_STRIDE, 4, address increment per beat (modulo 2**ADDR_WIDTH)
TIMEOUT_CYCLES, 255, cycles stb may stay high without ack/err before abort; 0 disables timeout

Ports:
clk_i  in  1  single clock, all logic on rising edge
rst_i  in  1  synchronous, active-high reset
cmd_valid_i  in  1  command offered
cmd_ready_o  out  1  command accepted when valid&ready
cmd_we_i  in  1  1=write burst, 0=read burst
cmd_addr_i  in  ADDR_WIDTH  first beat address
cmd_len_i  in  LEN_W  beats minus one
wr_data_i  in  DATA_WIDTH  write beat data
wr_data_valid_i  in  1  write data offered
wr_data_ready_o  out  1  write data accepted when valid&ready
rd_data_o  out  DATA_WIDTH  read beat data
rd_data_valid_o  out  1  one-cycle pulse per read beat
done_o  out  1  one-cycle pulse at burst end (normal or abort)
err_o  out  1  one-cycle pulse with done_o when burst aborted
beats_o  out  LEN_W+1  beats acked in last burst, valid with done_o
busy_o  out  1  high from command accept until done_o cycle inclusive
adr_o  out  ADDR_WIDTH  Wishbone address
dat_o  out  DATA_WIDTH  Wishbone write data
dat_i  in  DATA_WIDTH  Wishbone read data
we_o  out  1  Wishbone write enable
sel_o  out  DATA_WIDTH/8  byte selects, all ones while stb_o high, else 0
cyc_o  out  1  Wishbone cycle
stb_o  out  1  Wishbone strobe
ack_i  in  1  slave acknowledge
err_i  in  1  slave error

Behaviour:
- Reset (rst_i high at a clock edge): state IDLE.
  - All outputs 0, except cmd_ready_o=1 from the first cycle after reset.
  - Asserting rst_i mid-burst drops cyc_o/stb_o on the next edge. No done_o/err_o is emitted.
- States: IDLE, WFETCH, STROBE, FINISH.
- IDLE: cmd_ready_o=1. On cmd_valid_i, capture we, addr, len, clear beat counter and timeout counter.
  - Read command: go to STROBE.
  - Write command: go to WFETCH.
  - cmd_ready_o is 0 in all other states.
- WFETCH: cyc_o=1, stb_o=0, wr_data_ready_o=1 combinationally.
  - On wr_data_valid_i, latch wr_data_i into dat_o and go to STROBE.
  - cyc_o is held high while waiting; no timeout applies in WFETCH.
- STROBE: cyc_o=stb_o=1, we_o=captured we, adr_o=current address. Timeout counter increments each cycle.
  - err_i (takes priority over a simultaneous ack_i) or timeout counter == TIMEOUT_CYCLES (when nonzero): go to FINISH with abort flag set. The beat is not counted.
  - ack_i on a read: rd_data_o<=dat_i and rd_data_valid_o=1 for the next cycle.
  - ack_i (either direction): beat counter+1, address+=ADDR_STRIDE (wraps), timeout counter cleared.
    - If this was beat len+1: go to FINISH.
    - Else, read: stay in STROBE, with stb_o continuously high (back-to-back acks give one beat per cycle).
    - Else, write: go to WFETCH (stb_o low for at least one cycle).
- FINISH: one cycle.
  - cyc_o=stb_o=0, done_o=1, err_o=abort flag, beats_o=beat counter, busy_o=1.
  - Then go to IDLE.
  - Earliest next command is accepted the cycle after FINISH.
- Minimum read latency: command accepted at edge N, stb_o high from N+1; single-beat zero-wait ack at N+1 → rd_data_valid_o and done_o... done_o in FINISH at N+2 coincides with the rd_data_valid_o pulse.
- ack_i/err_i while stb_o=0 are ignored.
- cmd_len_i = 2**LEN_W-1 gives a 2**LEN_W beat burst; beats_o is wide enough to report it.

Test Plan:
- Read, addr 0x100, len 3, slave acks zero-wait → adr_o 0x100,0x104,0x108,0x10C on consecutive cycles; 4 rd_data_valid_o pulses with slave data; done_o=1, err_o=0, beats_o=4; cyc_o continuous.
- Write, len 1, wr data 0xDEADBEEF then 0xCAFEF00D offered 3 cycles late → stb_o drops between beats, dat_o matches per beat, cyc_o stays high, beats_o=2.
- Read len 7 at addr 0xFFFFFFF8 → third beat address 0x00000000 (wrap).
- Slave asserts err_i together with ack_i on beat 2 of a len-3 read → abort; done_o=1, err_o=1, beats_o=1; cyc_o low next cycle.
- TIMEOUT_CYCLES=10, slave never acks → stb_o high exactly 10 cycles, then done_o=1, err_o=1, beats_o=0; a new command is accepted afterwards.
- rst_i asserted during beat 3 of a write burst → cyc_o/stb_o/busy_o 0 next cycle, no done_o; cmd_ready_o=1 after reset.

Source files
------------

// File: rtl/wishbone_master_burst_if.sv
// Classic Wishbone bus between the burst master and a slave, named from the master's side.
interface wishbone_master_burst_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  localparam int unsigned SEL_W = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] adr_o;
  logic [DATA_WIDTH-1:0] dat_o;
  logic [DATA_WIDTH-1:0] dat_i;
  logic                  we_o;
  logic [SEL_W-1:0]      sel_o;
  logic                  cyc_o;
  logic                  stb_o;
  logic                  ack_i;
  logic                  err_i;

  modport master (
    output adr_o, dat_o, we_o, sel_o, cyc_o, stb_o,
    input  dat_i, ack_i, err_i
  );

  modport slave (
    input  adr_o, dat_o, we_o, sel_o, cyc_o, stb_o,
    output dat_i, ack_i, err_i
  );
endinterface

// File: rtl/wishbone_master_burst.sv
// Wishbone burst master: one command becomes a cyc-framed burst of stb beats
// with per-beat write fetch, read return, and err/timeout abort with status.
module wishbone_master_burst #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned LEN_W          = 4,
  parameter int unsigned ADDR_STRIDE    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [LEN_W-1:0]      cmd_len_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  wr_data_valid_i,
  output logic                  wr_data_ready_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_data_valid_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [LEN_W:0]        beats_o,
  output logic                  busy_o,
  wishbone_master_burst_if.master wb
);
  localparam int unsigned SEL_W = DATA_WIDTH / 8;
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(ADDR_STRIDE);

  typedef enum logic [1:0] {IDLE, WFETCH, STROBE, FINISH} state_e;

  state_e                state_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_W-1:0]      len_q;
  logic [LEN_W:0]        cnt_q;
  logic [TMO_W-1:0]      tmo_q;
  logic                  abort_q;
  logic [DATA_WIDTH-1:0] dat_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;

  logic tmo_hit;
  logic last_beat;

  // Abort on the TIMEOUT_CYCLES-th strobe cycle without a response.
  assign tmo_hit   = (TIMEOUT_CYCLES != 0) && (tmo_q == TMO_LAST);
  assign last_beat = (cnt_q == {1'b0, len_q});

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      abort_q    <= 1'b0;
      dat_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            we_q    <= cmd_we_i;
            addr_q  <= cmd_addr_i;
            len_q   <= cmd_len_i;
            cnt_q   <= '0;
            tmo_q   <= '0;
            abort_q <= 1'b0;
            state_q <= cmd_we_i ? WFETCH : STROBE;
          end
        end
        WFETCH: begin
          if (wr_data_valid_i) begin
            dat_q   <= wr_data_i;
            state_q <= STROBE;
          end
        end
        STROBE: begin
          tmo_q <= tmo_q + 1'b1;
          // err wins over a simultaneous ack; the aborted beat is not counted.
          if (wb.err_i || tmo_hit) begin
            abort_q <= 1'b1;
            state_q <= FINISH;
          end else if (wb.ack_i) begin
            if (!we_q) begin
              rd_data_q  <= wb.dat_i;
              rd_valid_q <= 1'b1;
            end
            cnt_q  <= cnt_q + 1'b1;
            addr_q <= addr_q + STRIDE;
            tmo_q  <= '0;
            if (last_beat) begin
              state_q <= FINISH;
            end else if (we_q) begin
              state_q <= WFETCH;
            end
          end
        end
        FINISH: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready_o     = (state_q == IDLE);
  assign wr_data_ready_o = (state_q == WFETCH);
  assign busy_o          = (state_q != IDLE);
  assign done_o          = (state_q == FINISH);
  assign err_o           = (state_q == FINISH) && abort_q;
  assign beats_o         = cnt_q;
  assign rd_data_o       = rd_data_q;
  assign rd_data_valid_o = rd_valid_q;

  assign wb.cyc_o = (state_q == WFETCH) || (state_q == STROBE);
  assign wb.stb_o = (state_q == STROBE);
  assign wb.we_o  = we_q && wb.cyc_o;
  assign wb.adr_o = addr_q;
  assign wb.dat_o = dat_q;
  assign wb.sel_o = {SEL_W{wb.stb_o}};
endmodule

// File: tb/tb_wishbone_master_burst.sv
// Directed bench for wishbone_master_burst: read/write bursts, address wrap,
// err abort, no-ack timeout and mid-burst reset.
`define CHK(tag, obs, exp) chk(tag, 64'(obs), 64'(exp))

module tb_wishbone_master_burst;
  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 32;
  localparam int unsigned LW  = 4;
  localparam int unsigned TMO = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic [DW-1:0] wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          done;
  logic          err;
  logic [LW:0]   beats;
  logic          busy;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wishbone_master_burst_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) wb ();

  wishbone_master_burst #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_W(LW),
    .ADDR_STRIDE(4), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
    .wr_data_i(wr_data), .wr_data_valid_i(wr_valid), .wr_data_ready_o(wr_ready),
    .rd_data_o(rd_data), .rd_data_valid_o(rd_valid),
    .done_o(done), .err_o(err), .beats_o(beats), .busy_o(busy),
    .wb(wb)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic we, input logic [AW-1:0] addr, input logic [LW-1:0] len);
    `CHK("cmd_ready_before", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_len   = len;
    tick();
    cmd_valid = 1'b0;
    `CHK("cmd_ready_after", cmd_ready, 0);
    `CHK("busy_after_accept", busy, 1);
  endtask

  // Zero-wait read burst: one ack per cycle with stb held high throughout.
  task automatic do_read(input logic [AW-1:0] addr, input logic [LW-1:0] len);
    send_cmd(1'b0, addr, len);
    for (int b = 0; b <= int'(len); b++) begin
      logic [AW-1:0] ea;
      logic [DW-1:0] d;
      ea = addr + AW'(4 * b);
      d  = 32'hA500_0000 ^ DW'(b) ^ addr;
      `CHK("rd_adr", wb.adr_o, ea);
      `CHK("rd_stb", wb.stb_o, 1);
      `CHK("rd_cyc", wb.cyc_o, 1);
      `CHK("rd_we", wb.we_o, 0);
      `CHK("rd_sel", wb.sel_o, 4'hF);
      wb.dat_i = d;
      wb.ack_i = 1'b1;
      tick();
      wb.ack_i = 1'b0;
      `CHK("rd_valid", rd_valid, 1);
      `CHK("rd_data", rd_data, d);
    end
    `CHK("rd_done", done, 1);
    `CHK("rd_err", err, 0);
    `CHK("rd_beats", beats, int'(len) + 1);
    `CHK("rd_cyc_finish", wb.cyc_o, 0);
    `CHK("rd_busy_finish", busy, 1);
    tick();
    `CHK("rd_idle_ready", cmd_ready, 1);
    `CHK("rd_idle_done", done, 0);
    `CHK("rd_idle_busy", busy, 0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; wr_valid = 1'b0;
    wb.dat_i = '0; wb.ack_i = 1'b0; wb.err_i = 1'b0;
    tick();
    tick();
    `CHK("rst_cmd_ready", cmd_ready, 1);
    `CHK("rst_cyc", wb.cyc_o, 0);
    `CHK("rst_stb", wb.stb_o, 0);
    `CHK("rst_busy", busy, 0);
    `CHK("rst_done", done, 0);
    `CHK("rst_sel", wb.sel_o, 0);
    `CHK("rst_rd_valid", rd_valid, 0);
    rst = 1'b0;
    tick();

    // Four-beat zero-wait read.
    do_read(32'h0000_0100, 4'd3);

    // Two-beat write, second data word offered late; acks during wait ignored.
    send_cmd(1'b1, 32'h0000_0200, 4'd1);
    `CHK("wr_fetch_cyc", wb.cyc_o, 1);
    `CHK("wr_fetch_stb", wb.stb_o, 0);
    `CHK("wr_fetch_ready", wr_ready, 1);
    wr_valid = 1'b1; wr_data = 32'hDEAD_BEEF;
    tick();
    wr_valid = 1'b0;
    `CHK("wr0_stb", wb.stb_o, 1);
    `CHK("wr0_we", wb.we_o, 1);
    `CHK("wr0_adr", wb.adr_o, 32'h0000_0200);
    `CHK("wr0_dat", wb.dat_o, 32'hDEAD_BEEF);
    `CHK("wr0_ready_low", wr_ready, 0);
    wb.ack_i = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      `CHK("wr_gap_stb", wb.stb_o, 0);
      `CHK("wr_gap_cyc", wb.cyc_o, 1);
      `CHK("wr_gap_sel", wb.sel_o, 0);
      vectors++;
      if (wb.cyc_o !== 1'b1) begin
        miscompares++;
        $error("FAIL wr_gap_cyc_direct: observed %0b expected 1", wb.cyc_o);
      end
      tick();
    end
    wb.ack_i = 1'b0;
    wr_valid = 1'b1; wr_data = 32'hCAFE_F00D;
    tick();
    wr_valid = 1'b0;
    `CHK("wr1_stb", wb.stb_o, 1);
    `CHK("wr1_adr", wb.adr_o, 32'h0000_0204);
    `CHK("wr1_dat", wb.dat_o, 32'hCAFE_F00D);
    wb.ack_i = 1'b1;
    tick();
    wb.ack_i = 1'b0;
    `CHK("wr_done", done, 1);
    `CHK("wr_err", err, 0);
    `CHK("wr_beats", beats, 2);
    `CHK("wr_rd_valid", rd_valid, 0);
    tick();

    // Eight-beat read wrapping through address zero on the third beat.
    do_read(32'hFFFF_FFF8, 4'd7);

    // Maximum-length burst reports 16 beats.
    do_read(32'h0000_1000, 4'd15);

    // err with ack on the second beat aborts; only the first beat counts.
    send_cmd(1'b0, 32'h0000_0500, 4'd3);
    wb.dat_i = 32'h1111_1111; wb.ack_i = 1'b1;
    tick();
    `CHK("errb_rd_valid0", rd_valid, 1);
    `CHK("errb_adr1", wb.adr_o, 32'h0000_0504);
    wb.dat_i = 32'h2222_2222; wb.err_i = 1'b1;
    tick();
    wb.ack_i = 1'b0; wb.err_i = 1'b0;
    `CHK("errb_done", done, 1);
    `CHK("errb_err", err, 1);
    `CHK("errb_beats", beats, 1);
    `CHK("errb_cyc", wb.cyc_o, 0);
    `CHK("errb_rd_valid1", rd_valid, 0);
    tick();
    `CHK("errb_idle_err", err, 0);

    // No response: stb high exactly TMO cycles, then abort with zero beats.
    send_cmd(1'b0, 32'h0000_0300, 4'd2);
    for (int i = 0; i < int'(TMO); i++) begin
      `CHK("tmo_stb_high", wb.stb_o, 1);
      `CHK("tmo_no_done", done, 0);
      vectors++;
      if (wb.stb_o !== 1'b1) begin
        miscompares++;
        $error("FAIL tmo_stb_direct: observed %0b expected 1 at cycle %0d", wb.stb_o, i);
      end
      tick();
    end
    `CHK("tmo_stb_low", wb.stb_o, 0);
    `CHK("tmo_done", done, 1);
    `CHK("tmo_err", err, 1);
    `CHK("tmo_beats", beats, 0);
    tick();
    // Single beat right after: rd_valid and done coincide two edges after accept.
    do_read(32'h0000_0400, 4'd0);

    // Reset during the third beat of a write burst.
    send_cmd(1'b1, 32'h0000_0600, 4'd3);
    for (int b = 0; b < 3; b++) begin
      `CHK("rstw_fetch_ready", wr_ready, 1);
      wr_valid = 1'b1; wr_data = 32'h0BAD_0000 + DW'(b);
      tick();
      wr_valid = 1'b0;
      `CHK("rstw_stb", wb.stb_o, 1);
      `CHK("rstw_dat", wb.dat_o, 32'h0BAD_0000 + b);
      if (b < 2) begin
        wb.ack_i = 1'b1;
        tick();
        wb.ack_i = 1'b0;
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    `CHK("rstw_cyc", wb.cyc_o, 0);
    `CHK("rstw_stb_low", wb.stb_o, 0);
    `CHK("rstw_busy", busy, 0);
    `CHK("rstw_done", done, 0);
    `CHK("rstw_err", err, 0);
    `CHK("rstw_ready", cmd_ready, 1);
    tick();
    `CHK("rstw_done_after", done, 0);
    `CHK("rstw_ready_after", cmd_ready, 1);

    if (miscompares != 0) begin
      $error("FAIL summary: %0d miscompares", miscompares);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
